pipo_rr_write_arbiter: RTL and testbench

- Round-robin arbiter that shares one WIDTH-bit parallel-in/parallel-out holding register between NREQ requesters.
- Each requester presents a data word and a request. The block grants one requester at a time, loads that requester's word into the shared register, and returns a one-cycle acknowledge.
- Sits in front of the shared register as its sole write controller. Downstream logic reads q, q_valid and owner.

---
 rtl/pipo_rr_write_arbiter.sv | 136 +++++++++++++
 tb/tb_pipo_rr_write_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pipo_rr_write_arbiter.sv
// Round-robin write controller for a shared WIDTH-bit holding register.
// One requester at a time is granted, its word is copied into the register
// and a one-cycle acknowledge is returned to it.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no grant in flight; search for a winner starting at ptr
// S_GRANT | winner latched in gidx; write happens at the end of this cycle
// S_ACK   | ack pulse is high for the winner; returns to idle afterwards
module pipo_rr_write_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IW    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         i_req,
    input  logic [NREQ*WIDTH-1:0]   i_wdata,
    output logic [NREQ-1:0]         o_ack,
    output logic [WIDTH-1:0]        o_q,
    output logic                    o_q_valid,
    output logic [IW-1:0]           o_owner,
    output logic                    o_busy,
    output logic                    o_drop_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IW-1:0]      r_gidx;
    logic [IW-1:0]      r_ptr;
    logic [WIDTH-1:0]   r_q;
    logic               r_q_valid;
    logic [IW-1:0]      r_owner;
    logic [NREQ-1:0]    r_ack;
    logic               r_drop_err;

    logic               w_found;
    logic [IW-1:0]      w_win;
    logic [IW:0]        w_idx;
    logic [WIDTH-1:0]   w_sel;
    logic [NREQ-1:0]    w_onehot;
    logic [IW-1:0]      w_ptr_nxt;
    logic               w_hold;

    // Round-robin search: first set request at ptr, ptr+1, ... wrapping to ptr-1.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, r_ptr} + (IW+1)'(k);
            if (w_idx >= (IW+1)'(NREQ)) begin
                w_idx = w_idx - (IW+1)'(NREQ);
            end
            if (!w_found && i_req[w_idx[IW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[IW-1:0];
            end
        end
    end

    assign w_hold    = i_req[r_gidx];
    assign w_sel     = i_wdata[int'(r_gidx)*WIDTH +: WIDTH];
    assign w_onehot  = {{(NREQ-1){1'b0}}, 1'b1} << r_gidx;
    assign w_ptr_nxt = (r_gidx == IW'(NREQ-1)) ? '0 : r_gidx + IW'(1);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; a dropped request during GRANT aborts back to idle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_nxt = S_GRANT;
            S_GRANT: w_state_nxt = w_hold ? S_ACK : S_IDLE;
            S_ACK:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Grant latch, shared-register write, ack pulse, pointer and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gidx     <= '0;
            r_ptr      <= '0;
            r_q        <= '0;
            r_q_valid  <= 1'b0;
            r_owner    <= '0;
            r_ack      <= '0;
            r_drop_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) r_gidx <= w_win;
                end
                S_GRANT: begin
                    if (w_hold) begin
                        r_q       <= w_sel;
                        r_q_valid <= 1'b1;
                        r_owner   <= r_gidx;
                        r_ack     <= w_onehot;
                        r_ptr     <= w_ptr_nxt;
                    end else begin
                        r_drop_err <= 1'b1;
                    end
                end
                S_ACK: begin
                    r_ack <= '0;
                end
                default: begin
                    r_ack <= '0;
                end
            endcase
        end
    end

    assign o_ack      = r_ack;
    assign o_q        = r_q;
    assign o_q_valid  = r_q_valid;
    assign o_owner    = r_owner;
    assign o_drop_err = r_drop_err;
    assign o_busy     = (r_state == S_GRANT) || (r_state == S_ACK);

endmodule

// File: tb/tb_pipo_rr_write_arbiter.sv
// Directed bench for pipo_rr_write_arbiter (NREQ=4, WIDTH=4).
module tb_pipo_rr_write_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  i_req;
    logic [15:0] i_wdata;
    logic [3:0]  o_ack;
    logic [3:0]  o_q;
    logic        o_q_valid;
    logic [1:0]  o_owner;
    logic        o_busy;
    logic        o_drop_err;

    int checks = 0;
    int errors = 0;

    pipo_rr_write_arbiter #(.NREQ(4), .WIDTH(4), .IW(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_req      (i_req),
        .i_wdata    (i_wdata),
        .o_ack      (o_ack),
        .o_q        (o_q),
        .o_q_valid  (o_q_valid),
        .o_owner    (o_owner),
        .o_busy     (o_busy),
        .o_drop_err (o_drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int e;
        rst     = 1'b1;
        i_req   = 4'b0000;
        i_wdata = 16'h0000;

        // Power-on reset
        tick(); tick();
        chk("por_ack",   o_ack,      4'b0000);
        chk("por_q",     o_q,        4'h0);
        chk("por_qv",    o_q_valid,  1'b0);
        chk("por_busy",  o_busy,     1'b0);
        chk("por_owner", o_owner,    2'd0);
        chk("por_derr",  o_drop_err, 1'b0);
        rst = 1'b0;

        // Reset in the middle of a grant abandons it
        i_req   = 4'b0001;
        i_wdata = 16'h000B;
        tick();
        chk("rg_busy_grant", o_busy, 1'b1);
        rst   = 1'b1;
        i_req = 4'b0000;
        tick(); tick();
        rst = 1'b0;
        chk("rg_ack",   o_ack,     4'b0000);
        chk("rg_q",     o_q,       4'h0);
        chk("rg_qv",    o_q_valid, 1'b0);
        chk("rg_busy",  o_busy,    1'b0);
        chk("rg_owner", o_owner,   2'd0);
        tick();
        chk("rg_q_after", o_q, 4'h0);

        // Single requester: ack two edges after req is presented
        i_req   = 4'b0001;
        i_wdata = 16'h000D;
        tick();
        chk("s_busy1", o_busy, 1'b1);
        chk("s_ack1",  o_ack,  4'b0000);
        chk("s_q1",    o_q,    4'h0);
        tick();
        chk("s_ack2",   o_ack,     4'b0001);
        chk("s_q2",     o_q,       4'hD);
        chk("s_owner2", o_owner,   2'd0);
        chk("s_qv2",    o_q_valid, 1'b1);
        i_req = 4'b0000;
        tick();
        chk("s_ack3",  o_ack,  4'b0000);
        chk("s_busy3", o_busy, 1'b0);
        chk("s_q3",    o_q,    4'hD);
        tick();
        chk("s_q4",    o_q,    4'hD);

        // All four requesting: order 0,1,2,3,0, one ack every 3 cycles
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        i_wdata = 16'h4321;
        i_req   = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            e = n % 4;
            tick();
            chk("rr_busy", o_busy, 1'b1);
            chk("rr_noack", o_ack, 4'b0000);
            tick();
            chk("rr_ack",   o_ack,   32'(1 << e));
            chk("rr_q",     o_q,     32'(e + 1));
            chk("rr_owner", o_owner, 32'(e));
            i_req[e] = 1'b0;
            tick();
            chk("rr_ackoff", o_ack, 4'b0000);
            i_req[e] = 1'b1;
        end
        i_req = 4'b0000;
        tick();

        // Pointer wrap: grant to 3, then 0 beats 3
        i_req = 4'b1000;
        tick(); tick();
        chk("w_ack3",   o_ack,   4'b1000);
        chk("w_q3",     o_q,     4'h4);
        chk("w_owner3", o_owner, 2'd3);
        i_req = 4'b0000;
        tick();
        i_req = 4'b1001;
        tick(); tick();
        chk("w_ack0",   o_ack,   4'b0001);
        chk("w_owner0", o_owner, 2'd0);
        chk("w_q0",     o_q,     4'h1);
        i_req = 4'b0000;
        tick();

        // Aborted grant: requester 2 drops during GRANT
        i_req = 4'b0100;
        tick();
        i_req = 4'b0000;
        tick();
        chk("ab_ack",   o_ack,      4'b0000);
        chk("ab_q",     o_q,        4'h1);
        chk("ab_owner", o_owner,    2'd0);
        chk("ab_derr",  o_drop_err, 1'b1);
        chk("ab_busy",  o_busy,     1'b0);
        tick();
        chk("ab_derr_sticky", o_drop_err, 1'b1);
        chk("ab_q_hold",      o_q,        4'h1);
        // ptr still 1, so requester 1 wins over 3
        i_wdata = 16'h4371;
        i_req   = 4'b1010;
        tick(); tick();
        chk("ab_next_ack",   o_ack,      4'b0010);
        chk("ab_next_owner", o_owner,    2'd1);
        chk("ab_next_q",     o_q,        4'h7);
        chk("ab_next_derr",  o_drop_err, 1'b1);
        i_req = 4'b0000;
        tick();

        // wdata sampled only at the GRANT edge
        i_wdata = 16'h4351;
        i_req   = 4'b0010;
        #2;
        i_wdata = 16'h43A1;
        tick();
        i_wdata = 16'h4351;
        tick();
        chk("ds_ack", o_ack, 4'b0010);
        chk("ds_q",   o_q,   4'h5);
        i_req   = 4'b0000;
        i_wdata = 16'h43A1;
        tick();
        chk("ds_q_after_ack", o_q, 4'h5);
        tick();
        chk("ds_q_idle", o_q, 4'h5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
